weird_sqrt: RTL and testbench

Iterative modular square-root finder: given an 8-bit (WIDTH-bit) target, searches for the smallest candidate x such that x*x mod 2^WIDTH equals the target, or reports that none exists. It is the inverse-direction companion of the repeated-squaring multiplier in the GSMITH utility set. It recovers a pre-image of a squared value for checking and back-tracing squaring chains. It uses a start/busy/done handshake and one comparison per cycle.

---
 rtl/weird_sqrt.sv | 97 +++++++++
 tb/tb_weird_sqrt.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/weird_sqrt.sv
// Iterative modular square-root finder: smallest x with x*x mod 2^WIDTH == target.
// Define WEIRD_SQRT_PARITY_SKIP_EN to search only candidates whose parity matches the target.
module weird_sqrt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] data_out
);

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t             state;
  logic [WIDTH-1:0]   target;
  logic [WIDTH-1:0]   cand;
  logic [WIDTH-1:0]   first_cand;
  logic [WIDTH-1:0]   last_cand;
  logic [WIDTH-1:0]   step;
  logic [2*WIDTH-1:0] sq;
  logic               match;

`ifdef WEIRD_SQRT_PARITY_SKIP_EN
  // x*x has the same parity as x, so only same-parity candidates can match.
  assign first_cand = {{(WIDTH-1){1'b0}}, data_in[0]};
  assign last_cand  = {{(WIDTH-1){1'b1}}, target[0]};
  assign step       = WIDTH'(2);
`else
  assign first_cand = '0;
  assign last_cand  = '1;
  assign step       = WIDTH'(1);
`endif

  function automatic logic [2*WIDTH-1:0] square_full(input logic [WIDTH-1:0] x);
    logic [2*WIDTH-1:0] xe;
    xe = {{WIDTH{1'b0}}, x};
    return xe * xe;
  endfunction

  assign sq    = square_full(cand);
  // Modular compare: the high half is a don't-care, only the low half must equal target.
  assign match = (sq == {sq[2*WIDTH-1:WIDTH], target});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      target   <= '0;
      cand     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      data_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            target <= data_in;
            cand   <= first_cand;
            state  <= SEARCH;
            busy   <= 1'b1;
          end
        end
        SEARCH: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (match) begin
            data_out <= cand;
            found    <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (cand == last_cand) begin
            data_out <= '0;
            found    <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cand <= cand + step;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weird_sqrt.sv
// Scoreboard bench for weird_sqrt: driver queues expected results, monitor checks on done.
module tb_weird_sqrt;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] data_in;
  logic       busy, done, found;
  logic [7:0] data_out;

  weird_sqrt #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .data_in(data_in),
    .busy(busy), .done(done), .found(found), .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic       fnd;
    logic [7:0] root;
    int         lat;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_done", int'(done), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk($sformatf("found_%02h", e.din), int'(found), int'(e.fnd));
        chk($sformatf("data_out_%02h", e.din), int'(data_out), int'(e.root));
        chk($sformatf("latency_%02h", e.din), cyc - start_cyc, e.lat);
      end
    end
  end

  // Called at a negedge; returns 1ns after the accepting edge with start released.
  task automatic issue(input logic [7:0] d, input logic f, input logic [7:0] r,
                       input int lat, input bit push);
    exp_t e;
    start   = 1'b1;
    data_in = d;
    if (push) begin
      e.din = d; e.fnd = f; e.root = r; e.lat = lat;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start     = 1'b0;
    chk($sformatf("busy_after_start_%02h", d), int'(busy), 1);
  endtask

  // Leaves the caller at the negedge where done is seen.
  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk({"timeout_", name}, 0, 1);
  endtask

`ifdef WEIRD_SQRT_PARITY_SKIP_EN
  localparam int LAT_19 = 3, LAT_11 = 12, LAT_02 = 128;
`else
  localparam int LAT_19 = 6, LAT_11 = 24, LAT_02 = 256;
`endif

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_found", int'(found), 0);
    chk("rst_data_out", int'(data_out), 0);
    rst = 1'b1;
    @(negedge clk);

    // Root at candidate 0: busy for exactly one cycle.
    issue(8'h00, 1'b1, 8'h00, 1, 1);
    @(posedge clk); #1;
    chk("busy_one_cycle_00", int'(busy), 0);
    wait_done("00");
    @(negedge clk);

    issue(8'h19, 1'b1, 8'h05, LAT_19, 1);
    wait_done("19");
    @(negedge clk);

    issue(8'h11, 1'b1, 8'h17, LAT_11, 1);
    wait_done("11");
    @(negedge clk);

    issue(8'h02, 1'b0, 8'h00, LAT_02, 1);
    wait_done("02");
    @(negedge clk);

    // Re-establish found=1/data_out=0x17 so the abort check has something to preserve.
    issue(8'h11, 1'b1, 8'h17, LAT_11, 1);
    wait_done("11b");
    @(negedge clk);

    // Abort: no done, ignored start mid-search, previous result held.
    issue(8'h11, 1'b0, 8'h00, 0, 0);
    repeat (4) @(negedge clk);
    start = 1'b1; data_in = 8'h19;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_found_held", int'(found), 1);
    chk("abort_data_held", int'(data_out), 8'h17);
    repeat (30) @(negedge clk);
    issue(8'h19, 1'b1, 8'h05, LAT_19, 1);
    wait_done("19_after_abort");
    @(negedge clk);

    // Asynchronous reset mid-search.
    issue(8'h11, 1'b0, 8'h00, 0, 0);
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_found", int'(found), 0);
    chk("midrst_data_out", int'(data_out), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);

    // Back-to-back: start accepted in the done cycle.
    issue(8'h19, 1'b1, 8'h05, LAT_19, 1);
    wait_done("19_b2b");
    issue(8'h00, 1'b1, 8'h00, 1, 1);
    wait_done("00_b2b");
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
